// File: rtl/rr_arbiter8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

    localparam int N        = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: rotate by ptr, find lowest set bit, map back.
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] ofs;

    // Bit 0 of rot is requester ptr, bit k is requester ptr+k (wrapping).
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N-1:0];

    always_comb begin
        ofs = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                ofs = IDX_W'(k);
            end
        end
    end

    assign found = |rot;
    assign idx   = ptr + ofs;

endmodule

// File: rtl/rr_arbiter8.sv
// Registered round-robin arbiter: holds a grant until ack, request drop or
// hold timeout, then inserts a one-cycle bubble and rotates priority.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             grant_ack,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
    logic              grant_valid_q, grant_valid_d;
    logic              timeout_q, timeout_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic              rel_ack, rel_drop, rel_tmo;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign rel_ack  = grant_ack;
    assign rel_drop = ~req[grant_idx_q];
    assign rel_tmo  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_idx_d   = pick_idx;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = '0;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                if (rel_ack || rel_drop || rel_tmo) begin
                    // Ack or drop takes precedence over a coincident timeout.
                    state_d   = IDLE;
                    ptr_d     = grant_idx_q + IDX_W'(1);
                    timeout_d = rel_tmo && !rel_ack && !rel_drop;
                end else begin
                    grant_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and random checks of rr_arbiter8 against a cycle-level reference
// model that tracks who holds the grant and for how many cycles.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 15;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       grant_ack;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_held;
    bit m_to;

    rr_arbiter8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant_ack   (grant_ack),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_update(input logic [7:0] r, input logic a);
        bit found;
        bit drop;
        bit tmo;
        if (!m_valid) begin
            m_to = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!found && r[(m_ptr + k) % 8]) begin
                    found = 1'b1;
                    m_idx = (m_ptr + k) % 8;
                end
            end
            if (found) begin
                m_valid = 1'b1;
                m_held  = 1;
            end
        end else begin
            drop = !r[m_idx];
            tmo  = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
            if (a || drop || tmo) begin
                m_valid = 1'b0;
                m_ptr   = (m_idx + 1) % 8;
                m_to    = tmo && !a && !drop;
            end else begin
                m_held++;
                m_to = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [7:0] r, input logic a);
        req       = r;
        grant_ack = a;
        @(posedge clk);
        model_update(r, a);
        #1;
        $display("step req=%h ack=%b -> valid=%b idx=%0d timeout=%b", r, a, grant_valid, grant_idx, timeout);
        check("valid", grant_valid, m_valid);
        check("idx", grant_idx, m_idx);
        check("timeout", timeout, m_to);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        grant_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", grant_valid, 0);
        check("rst_idx", grant_idx, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int  cnt;
        bit  done;
        logic [7:0] r;

        rst_n = 1'b1;
        req = '0;
        grant_ack = 1'b0;
        model_reset();
        #2;

        // Reset then single request, ack releases, ptr moves to 3
        do_reset();
        step(8'h04, 1'b0);
        check("single_idx", grant_idx, 2);
        check("single_valid", grant_valid, 1);
        step(8'h04, 1'b1);
        check("single_release", grant_valid, 0);
        step(8'hFF, 1'b0);
        check("single_ptr3", grant_idx, 3);
        step(8'hFF, 1'b1);

        // Rotation fairness with all requesters active
        do_reset();
        for (int g = 0; g < 9; g++) begin
            step(8'hFF, 1'b0);
            check("rot_idx", grant_idx, g % 8);
            step(8'hFF, 1'b1);
            check("rot_bubble", grant_valid, 0);
        end

        // Wrap-around from ptr=6 and ptr=7
        do_reset();
        step(8'h20, 1'b0);
        step(8'h20, 1'b1);
        step(8'h03, 1'b0);
        check("wrap6_first", grant_idx, 0);
        step(8'h03, 1'b1);
        step(8'h03, 1'b0);
        check("wrap6_second", grant_idx, 1);
        step(8'h03, 1'b1);
        step(8'h40, 1'b0);
        step(8'h40, 1'b1);
        step(8'h81, 1'b0);
        check("wrap7_first", grant_idx, 7);
        step(8'h81, 1'b1);
        step(8'h81, 1'b0);
        check("wrap7_second", grant_idx, 0);
        step(8'h81, 1'b1);

        // Timeout: held request, no ack
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step(8'h10, 1'b0);
            if (grant_valid) cnt++;
            else if (cnt > 0) done = 1'b1;
        end
        check("to_bound", done, 1);
        check("to_len", cnt, MAX_HOLD);
        check("to_pulse", timeout, 1);
        step(8'h10, 1'b0);
        check("to_regrant_idx", grant_idx, 4);
        check("to_regrant_valid", grant_valid, 1);
        check("to_pulse_once", timeout, 0);

        // Same hold with ack on the 15th cycle: no timeout pulse
        cnt  = 1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step(8'h10, cnt == MAX_HOLD);
            if (grant_valid) cnt++;
            else done = 1'b1;
        end
        check("ack15_bound", done, 1);
        check("ack15_len", cnt, MAX_HOLD);
        check("ack15_no_timeout", timeout, 0);

        // Request drop mid-grant
        step(8'h08, 1'b0);
        check("drop_idx", grant_idx, 3);
        step(8'h08, 1'b0);
        step(8'h00, 1'b0);
        check("drop_release", grant_valid, 0);
        check("drop_no_timeout", timeout, 0);
        step(8'hFF, 1'b0);
        check("drop_ptr4", grant_idx, 4);
        step(8'hFF, 1'b1);

        // Ack while idle is ignored
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);

        // Asynchronous reset in the middle of a grant
        step(8'h20, 1'b0);
        check("areset_pre_idx", grant_idx, 5);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("areset_valid", grant_valid, 0);
        check("areset_idx", grant_idx, 0);
        check("areset_timeout", timeout, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'hFF, 1'b0);
        check("areset_regrant", grant_idx, 0);
        step(8'hFF, 1'b1);

        // Random traffic against the model
        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            step(r, $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Registered round-robin arbiter for 8 requesters.
- Produces a binary 3-bit grant index plus a valid flag. This feeds directly into the 3-to-8 decoder, which converts the index into a one-hot select.
- Holds each grant until it is acknowledged, the request is dropped, or a hold timeout expires. It then rotates priority so that no requester starves.

Parameters:
- N, 8: number of requesters. Fixed at 8 to match the decoder.
- IDX_W, 3: grant index width (log2 N).
- MAX_HOLD, 15: maximum number of cycles a grant may be held. 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request vector. Bit i is requester i. Must stay high until served.
- grant_ack  input  1  single-cycle pulse from the consumer. Meaning: done, release the grant.
- grant_idx  output  IDX_W  index of the granted requester. Feeds the decoder `in`.
- grant_valid  output  1  high while grant_idx is a live grant.
- timeout  output  1  one-cycle pulse when a grant is released by MAX_HOLD expiry.

Behaviour:
- One clock. Reset is asynchronous and active-low: clk and rst_n.
- Reset values, applied immediately on rst_n=0 regardless of clk:
  - state=IDLE, grant_idx=0, grant_valid=0, timeout=0, ptr=0, hold_cnt=0.
- Internal registers:
  - ptr (IDX_W bits): the highest-priority index for the next arbitration.
  - hold_cnt: width sufficient for MAX_HOLD, saturating.
- All outputs are registered. There is no combinational path from req or grant_ack to any output.
- State IDLE:
  - grant_valid=0.
  - If req != 0, the winner is the first set bit searching ptr, ptr+1, …, ptr+7, with indices wrapping mod 8.
  - Next cycle: grant_idx=winner, grant_valid=1, hold_cnt=0, state=GRANT.
  - Latency from req sampled in IDLE to grant_valid=1 is exactly 1 cycle.
  - If req == 0: stay in IDLE. grant_idx holds its last value.
- State GRANT:
  - grant_idx is stable for the entire grant.
  - hold_cnt increments each cycle.
  - Release condition, evaluated each cycle:
    - (a) grant_ack=1, or
    - (b) req[grant_idx]=0, or
    - (c) MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1, so the grant lasts exactly MAX_HOLD cycles.
  - On release:
    - the next cycle has grant_valid=0 and state=IDLE;
    - ptr = grant_idx+1 mod 8, so 7 wraps to 0.
  - timeout=1 for that one cycle only if (c) caused the release and neither (a) nor (b) was true in the same cycle. Ack/drop wins over timeout.
  - Changes on other req bits during GRANT are ignored until IDLE.
- Mandatory bubble: every release is followed by at least one cycle of grant_valid=0. The downstream decoder select therefore never switches between two live grants back-to-back.
- Minimum re-grant spacing: grant_valid is high for ≥1 cycle, then low for ≥1 cycle.
- grant_ack while in IDLE is ignored.
- Reset asserted mid-GRANT:
  - all registers clear asynchronously and ptr returns to 0;
  - the first arbitration after release of reset favours index 0.
- Width rules: ptr and index arithmetic are strictly IDX_W bits with natural wrap. N is a power of two, so no modulo logic is needed.

Decomposition:
- Shared package:
  - N, IDX_W, MAX_HOLD defaults;
  - state encoding constants: IDLE=1'b0, GRANT=1'b1.
- One sub-module: rr_pick8. Purely combinational rotate, priority-find, unrotate.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: found, idx[2:0].
  - It is instantiated once. The FSM, counters and registers stay in rr_arbiter8.

Test Plan:
- Reset then single request: rst_n low 2 cycles, then req=8'b0000_0100 → cycle+1 grant_idx=2, grant_valid=1. On grant_ack pulse → next cycle grant_valid=0, ptr=3.
- Rotation fairness: req=8'hFF held, ack every grant after 2 cycles → grant_idx sequence 0,1,2,…,7,0, with one valid=0 bubble between each grant.
- Wrap-around: ptr=6 (after serving 5), req=8'b0000_0011 → grant_idx=0, then 1. req=8'b1000_0001 with ptr=7 → grant_idx=7, then 0.
- Timeout: MAX_HOLD=15, req=8'b0001_0000 held, no ack → grant_valid high exactly 15 cycles, timeout pulses 1 cycle, then re-grant of 4 after the bubble. Same run with ack on cycle 15 → timeout stays 0.
- Request drop: grant on idx 3, then req[3]→0 mid-grant, no ack → release next cycle, timeout=0, ptr=4.
- Async reset mid-grant: grant_idx=5 valid, pull rst_n low between clock edges → grant_valid=0 and grant_idx=0 immediately. After release with req=8'hFF → grant_idx=0.
